wr_port_arbiter: RTL and testbench

//  Four-requester round-robin arbiter for the register-file write port. Selects one

---
 rtl/arb_pkg.sv | 6 +
 rtl/decoder2_4.sv | 15 +
 rtl/wr_port_arbiter.sv | 119 +++++++++++
 tb/tb_wr_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the register-file write-port arbiter
package arb_pkg;
   localparam int NUM_REQ = 4;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;
   typedef logic [1:0] req_idx_t;
endpackage

// File: rtl/decoder2_4.sv
// rtl/decoder2_4.sv - enabled 2:4 one-hot decoder used to form the grant vector
module decoder2_4
   import arb_pkg::*;
(
   input  logic               i_en,
   input  req_idx_t           i_sel,
   output logic [NUM_REQ-1:0] o_dec
);

   always_comb begin
      o_dec = '0;
      if (i_en) o_dec[i_sel] = 1'b1;
   end

endmodule

// File: rtl/wr_port_arbiter.sv
// rtl/wr_port_arbiter.sv - four-way round-robin arbiter feeding one registered write port
// Bursts per grant are capped at MAX_BURST beats; an IDLE cycle separates every grant.
module wr_port_arbiter
   import arb_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 5,
   parameter int MAX_BURST = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              last,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  data,
   output logic [NUM_REQ-1:0]              gnt,
   output logic                            wr_en,
   output logic [1:0]                      wr_src,
   output logic [ADDR_W-1:0]               wr_addr,
   output logic [DATA_W-1:0]               wr_data
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t          r_state, w_state_nxt;
   req_idx_t            r_owner, w_owner_nxt;
   req_idx_t            r_rr_ptr, w_rr_ptr_nxt;
   req_idx_t            w_rot_idx, w_pick;
   logic [CNT_W-1:0]    r_beat_cnt, w_beat_cnt_nxt, w_cnt_inc;
   logic [NUM_REQ-1:0]  w_gnt, w_req_rot;
   logic                w_xfer;
   logic                r_wr_en;
   req_idx_t            r_wr_src;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;

   // Grant depends on registered state only, so there is no req->gnt combinational path.
   decoder2_4 u_gnt_dec (
      .i_en  (r_state == BUSY),
      .i_sel (r_owner),
      .o_dec (w_gnt)
   );

   always_comb begin
      w_req_rot = '0;
      for (int k = 0; k < NUM_REQ; k++)
         w_req_rot[k] = req[req_idx_t'(r_rr_ptr + req_idx_t'(k))];
      w_rot_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (w_req_rot[k]) w_rot_idx = req_idx_t'(k);
      w_pick = r_rr_ptr + w_rot_idx;
   end

   assign w_xfer    = req[r_owner] & w_gnt[r_owner];
   assign w_cnt_inc = r_beat_cnt + CNT_W'(1);

   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_beat_cnt_nxt = r_beat_cnt;
      case (r_state)
         IDLE: begin
            if (|req) begin
               w_state_nxt    = BUSY;
               w_owner_nxt    = w_pick;
               w_beat_cnt_nxt = '0;
            end
         end
         BUSY: begin
            if (w_xfer) w_beat_cnt_nxt = w_cnt_inc;
            // Close the grant on last beat, fairness cap, or owner release.
            if ((w_xfer && (last[r_owner] || w_cnt_inc == CNT_W'(MAX_BURST))) || !req[r_owner]) begin
               w_state_nxt    = IDLE;
               w_rr_ptr_nxt   = r_owner + req_idx_t'(1);
               w_beat_cnt_nxt = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk, posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_owner    <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

   always_ff @(posedge clk, posedge reset) begin
      if (reset) begin
         r_wr_en   <= 1'b0;
         r_wr_src  <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_xfer;
         if (w_xfer) begin
            r_wr_src  <= r_owner;
            r_wr_addr <= addr[r_owner];
            r_wr_data <= data[r_owner];
         end
      end
   end

   assign gnt     = w_gnt;
   assign wr_en   = r_wr_en;
   assign wr_src  = r_wr_src;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb/tb_wr_port_arbiter.sv - self-checking bench for wr_port_arbiter against a behavioural model
module tb_wr_port_arbiter;
   localparam int DATA_W    = 64;
   localparam int ADDR_W    = 5;
   localparam int MAX_BURST = 4;

   logic                         clk = 1'b0;
   logic                         reset;
   logic [3:0]                   req, last;
   logic [3:0][ADDR_W-1:0]       addr;
   logic [3:0][DATA_W-1:0]       data;
   logic [3:0]                   gnt;
   logic                         wr_en;
   logic [1:0]                   wr_src;
   logic [ADDR_W-1:0]            wr_addr;
   logic [DATA_W-1:0]            wr_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wr_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .reset(reset), .req(req), .last(last), .addr(addr), .data(data),
      .gnt(gnt), .wr_en(wr_en), .wr_src(wr_src), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   // Reference model: who holds the port, whose turn is next, beats so far in this grant.
   bit               m_busy;
   int               m_owner, m_ptr, m_cnt, m_wr_src;
   logic             m_wr_en;
   logic [ADDR_W-1:0] m_wr_addr;
   logic [DATA_W-1:0] m_wr_data;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
         m_wr_en = 0; m_wr_src = 0; m_wr_addr = '0; m_wr_data = '0;
      end else if (!m_busy) begin
         bit found;
         m_wr_en = 0;
         found = 0;
         for (int k = 0; k < 4; k++) begin
            if (!found && req[(m_ptr + k) % 4]) begin
               m_owner = (m_ptr + k) % 4;
               found = 1;
            end
         end
         if (found) begin
            m_busy = 1;
            m_cnt = 0;
         end
      end else if (req[m_owner]) begin
         m_wr_en = 1;
         m_wr_src = m_owner;
         m_wr_addr = addr[m_owner];
         m_wr_data = data[m_owner];
         m_cnt++;
         if (last[m_owner] || m_cnt == MAX_BURST) begin
            m_busy = 0; m_ptr = (m_owner + 1) % 4; m_cnt = 0;
         end
      end else begin
         m_wr_en = 0;
         m_busy = 0; m_ptr = (m_owner + 1) % 4; m_cnt = 0;
      end
   end

   logic       prev_xfer;
   logic [3:0] prev_gnt;
   logic [3:0] exp_gnt;
   int         waits [4];

   always @(negedge clk) begin
      if (reset) begin
         prev_xfer = 0;
         prev_gnt = 0;
         for (int j = 0; j < 4; j++) waits[j] = 0;
      end else begin
         exp_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
         n_cmp++;
         if (gnt !== exp_gnt) begin
            n_bad++; $display("FAIL model_gnt: got %b expected %b at %0t", gnt, exp_gnt, $time);
         end
         n_cmp++;
         if (wr_en !== m_wr_en) begin
            n_bad++; $display("FAIL model_wr_en: got %b expected %b at %0t", wr_en, m_wr_en, $time);
         end
         n_cmp++;
         if (wr_src !== 2'(m_wr_src) || wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
            n_bad++;
            $display("FAIL model_wr_beat: got src=%0d addr=%h data=%h expected src=%0d addr=%h data=%h at %0t",
                     wr_src, wr_addr, wr_data, m_wr_src, m_wr_addr, m_wr_data, $time);
         end
         n_cmp++;
         if (!$onehot0(gnt)) begin
            n_bad++; $display("FAIL gnt_onehot0: got %b expected at most one bit at %0t", gnt, $time);
         end
         if (wr_en === 1'b1) begin
            n_cmp++;
            if (prev_xfer !== 1'b1) begin
               n_bad++; $display("FAIL wr_en_cause: got wr_en=1 expected a transfer in prior cycle at %0t", $time);
            end
         end
         prev_xfer = |(req & gnt);
         if (gnt != 0 && prev_gnt == 0) begin
            for (int j = 0; j < 4; j++) begin
               if (gnt[j]) waits[j] = 0;
               else if (req[j]) waits[j]++;
               else waits[j] = 0;
               n_cmp++;
               if (waits[j] > 3) begin
                  n_bad++; $display("FAIL starvation: requester %0d got %0d waits expected <=3", j, waits[j]);
               end
            end
         end
         prev_gnt = gnt;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = '0; last = '0; addr = '0; data = '0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
      n_cmp++; if (wr_src !== 2'd0) begin n_bad++; $display("FAIL reset_wr_src: got %0d expected 0", wr_src); end
      n_cmp++; if (wr_addr !== '0) begin n_bad++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
      n_cmp++; if (wr_data !== '0) begin n_bad++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
   endtask

   task automatic test_single_beat();
      do_reset();
      req = 4'b0100; last = 4'b0100;
      addr[2] = 5'h0A; data[2] = 64'hDEAD;
      tick();
      n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
      n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL single_no_early_wr: got %b expected 0", wr_en); end
      tick();
      req = 4'b0000;
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== 5'h0A || wr_data !== 64'hDEAD || wr_src !== 2'd2) begin
         n_bad++;
         $display("FAIL single_write: got en=%b addr=%h data=%h src=%0d expected 1 0a dead 2",
                  wr_en, wr_addr, wr_data, wr_src);
      end
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_idle: got %b expected 0000", gnt); end
      tick();
      n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL single_one_pulse: got %b expected 0", wr_en); end
   endtask

   task automatic test_round_robin();
      int srcs[$];
      int exp_rr[5] = '{0, 1, 2, 3, 0};
      int t_last = -1;
      do_reset();
      req = 4'b1111; last = 4'b1111;
      for (int cyc = 0; cyc < 40 && srcs.size() < 5; cyc++) begin
         tick();
         if (wr_en) begin
            if (t_last >= 0) begin
               n_cmp++;
               if (cyc - t_last != 2) begin
                  n_bad++; $display("FAIL rr_spacing: got %0d cycles expected 2", cyc - t_last);
               end
            end
            srcs.push_back(int'(wr_src));
            t_last = cyc;
         end
      end
      req = '0;
      n_cmp++;
      if (srcs.size() != 5) begin
         n_bad++; $display("FAIL rr_timeout: got %0d writes expected 5", srcs.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (srcs[i] != exp_rr[i]) begin
               n_bad++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, srcs[i], exp_rr[i]);
            end
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_burst_cap();
      int srcs[$];
      int exp_seq[7] = '{1, 1, 1, 1, 2, 1, 1};
      int n1 = 0;
      do_reset();
      req = 4'b0110; last = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         addr[i] = 5'($urandom);
         data[i] = {$urandom, $urandom};
      end
      for (int cyc = 0; cyc < 60 && req != 0; cyc++) begin
         tick();
         if (wr_en) begin
            srcs.push_back(int'(wr_src));
            if (wr_src == 2'd1) n1++;
            if (wr_src == 2'd2) req[2] = 1'b0;
         end
         if (n1 == 6) req[1] = 1'b0;
      end
      n_cmp++;
      if (req != 0) begin n_bad++; $display("FAIL burst_timeout: got req=%b expected all served", req); end
      req = '0;
      repeat (4) begin
         tick();
         if (wr_en) srcs.push_back(int'(wr_src));
      end
      n_cmp++;
      if (srcs.size() != 7) begin
         n_bad++; $display("FAIL burst_count: got %0d writes expected 7", srcs.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (srcs[i] != exp_seq[i]) begin
               n_bad++; $display("FAIL burst_order[%0d]: got %0d expected %0d", i, srcs[i], exp_seq[i]);
            end
         end
      end
   endtask

   task automatic test_release();
      int nw = 0;
      do_reset();
      req = 4'b1000; last = 4'b0000;
      for (int cyc = 0; cyc < 20 && nw < 2; cyc++) begin
         tick();
         if (wr_en) nw++;
      end
      req = 4'b0000;
      tick();
      if (wr_en) nw++;
      n_cmp++; if (nw != 2) begin n_bad++; $display("FAIL release_writes: got %0d expected 2", nw); end
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL release_idle: got %b expected 0000", gnt); end
      req = 4'b1001;
      tick();
      n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL release_ptr: got %b expected 0001", gnt); end
      req = '0;
      repeat (3) tick();
   endtask

   task automatic test_async_reset();
      bit seen = 0;
      do_reset();
      req = 4'b0001; last = 4'b0000;
      data[0] = {$urandom, $urandom};
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
         tick();
         if (wr_en) seen = 1;
      end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL areset_timeout: got no write expected one"); end
      req = 4'b0101;
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL areset_gnt: got %b expected 0000", gnt); end
      n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL areset_wr_en: got %b expected 0", wr_en); end
      n_cmp++; if (wr_data !== '0) begin n_bad++; $display("FAIL areset_wr_data: got %h expected 0", wr_data); end
      @(posedge clk); #1;
      reset = 1'b0;
      tick();
      n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL areset_regrant: got %b expected 0001", gnt); end
      req = '0;
      repeat (3) tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int j = 0; j < 4; j++) begin
            if (gnt[j]) req[j] = ($urandom_range(0, 4) != 0);
            else if (!req[j]) req[j] = ($urandom_range(0, 2) == 0);
            last[j] = ($urandom_range(0, 3) == 0);
            addr[j] = 5'($urandom);
            data[j] = {$urandom, $urandom};
         end
         tick();
      end
      req = '0;
      repeat (6) tick();
   endtask

   initial begin
      reset = 1'b0;
      req = '0; last = '0; addr = '0; data = '0;
      #1;
      test_reset();
      test_single_beat();
      test_round_robin();
      test_burst_cap();
      test_release();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1);
   end

endmodule
